// File: rtl/fp_issue_ctrl.sv
// Core-side issue/result controller for the FPU: single in-flight op, WB routing, flush, watchdog.
// Optional FP_FFLAGS_ACCUM_EN adds an accumulated fflags register (fflags_o / fflags_clr_i).
module fp_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  output logic        id_ready_o,
  input  logic [31:0] id_instr_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_int_wb_i,
  input  logic        flush_i,
  output logic        fpu_valid_o,
  output logic [31:0] fpu_instr_o,
  input  logic        fpu_in_ready_i,
  output logic        fpu_flush_o,
  input  logic        fpu_out_valid_i,
  output logic        fpu_out_ready_o,
  input  logic [31:0] fpu_result_i,
  input  logic [4:0]  fpu_status_i,
  output logic        fp_wb_en_o,
  output logic        int_wb_en_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        stall_o,
`ifdef FP_FFLAGS_ACCUM_EN
  output logic [4:0]  fflags_o,
  input  logic        fflags_clr_i,
`endif
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB
  } state_e;

  // The TIMEOUT_CYCLES-th WAIT cycle is the one where the counter would reach the limit.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       instr_q, instr_d;
  logic [4:0]        rd_q, rd_d;
  logic              int_wb_q, int_wb_d;
  logic [31:0]       result_q, result_d;
  logic              timeout_q, timeout_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    state_d         = state_q;
    cnt_d           = cnt_q;
    instr_d         = instr_q;
    rd_d            = rd_q;
    int_wb_d        = int_wb_q;
    result_d        = result_q;
    timeout_d       = timeout_q;
    id_ready_o      = 1'b0;
    stall_o         = 1'b0;
    fpu_valid_o     = 1'b0;
    fpu_out_ready_o = 1'b0;
    fpu_flush_o     = 1'b0;
    fp_wb_en_o      = 1'b0;
    int_wb_en_o     = 1'b0;
    wb_addr_o       = '0;
    wb_data_o       = '0;

    if (flush_i) begin
      // Flush aborts whatever is in progress: no handshakes, no write-back, no timeout.
      state_d     = S_IDLE;
      cnt_d       = '0;
      fpu_flush_o = 1'b1;
      stall_o     = (state_q != S_IDLE);
    end else begin
      unique case (state_q)
        S_IDLE: begin
          id_ready_o = 1'b1;
          cnt_d      = '0;
          if (id_valid_i) begin
            instr_d  = id_instr_i;
            rd_d     = id_rd_i;
            int_wb_d = id_int_wb_i;
            stall_o  = 1'b1;
            state_d  = S_ISSUE;
          end
        end
        S_ISSUE: begin
          fpu_valid_o = 1'b1;
          stall_o     = 1'b1;
          cnt_d       = '0;
          if (fpu_in_ready_i) state_d = S_WAIT;
        end
        S_WAIT: begin
          fpu_out_ready_o = 1'b1;
          stall_o         = 1'b1;
          if (fpu_out_valid_i) begin
            result_d = fpu_result_i;
            cnt_d    = '0;
            state_d  = S_WB;
          end else if (cnt_q == CNT_LAST) begin
            timeout_d   = 1'b1;
            fpu_flush_o = 1'b1;
            cnt_d       = '0;
            state_d     = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WB: begin
          stall_o     = 1'b1;
          fp_wb_en_o  = ~int_wb_q;
          int_wb_en_o = int_wb_q;
          wb_addr_o   = rd_q;
          wb_data_o   = result_q;
          state_d     = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Handshake outputs stay quiet while reset is held.
    if (rst_i) begin
      id_ready_o      = 1'b0;
      stall_o         = 1'b0;
      fpu_valid_o     = 1'b0;
      fpu_out_ready_o = 1'b0;
      fpu_flush_o     = 1'b0;
      fp_wb_en_o      = 1'b0;
      int_wb_en_o     = 1'b0;
      wb_addr_o       = '0;
      wb_data_o       = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      instr_q   <= '0;
      rd_q      <= '0;
      int_wb_q  <= 1'b0;
      result_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      instr_q   <= instr_d;
      rd_q      <= rd_d;
      int_wb_q  <= int_wb_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
    end
  end

  assign fpu_instr_o = instr_q;
  assign timeout_o   = timeout_q;

`ifdef FP_FFLAGS_ACCUM_EN
  logic [4:0] status_q, status_d;
  logic [4:0] fflags_q, fflags_d;

  always_comb begin
    status_d = status_q;
    fflags_d = fflags_clr_i ? 5'b0 : fflags_q;
    if (!flush_i && state_q == S_WAIT && fpu_out_valid_i) status_d = fpu_status_i;
    if (!flush_i && state_q == S_WB) fflags_d = fflags_d | status_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      status_q <= '0;
      fflags_q <= '0;
    end else begin
      status_q <= status_d;
      fflags_q <= fflags_d;
    end
  end

  assign fflags_o = fflags_q;
`else
  logic status_unused;
  assign status_unused = ^fpu_status_i;
`endif

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Self-checking bench for fp_issue_ctrl: directed test-plan ops plus randomized transactions,
// each checked cycle by cycle against a transaction-timeline reference model.
module tb_fp_issue_ctrl;

  localparam int T = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic        id_ready_o;
  logic [31:0] id_instr_i;
  logic [4:0]  id_rd_i;
  logic        id_int_wb_i;
  logic        flush_i;
  logic        fpu_valid_o;
  logic [31:0] fpu_instr_o;
  logic        fpu_in_ready_i;
  logic        fpu_flush_o;
  logic        fpu_out_valid_i;
  logic        fpu_out_ready_o;
  logic [31:0] fpu_result_i;
  logic [4:0]  fpu_status_i;
  logic        fp_wb_en_o;
  logic        int_wb_en_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;
  logic        stall_o;
  logic        timeout_o;
`ifdef FP_FFLAGS_ACCUM_EN
  logic [4:0]  fflags_o;
  logic        fflags_clr_i;
`endif

  fp_issue_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .id_valid_i     (id_valid_i),
    .id_ready_o     (id_ready_o),
    .id_instr_i     (id_instr_i),
    .id_rd_i        (id_rd_i),
    .id_int_wb_i    (id_int_wb_i),
    .flush_i        (flush_i),
    .fpu_valid_o    (fpu_valid_o),
    .fpu_instr_o    (fpu_instr_o),
    .fpu_in_ready_i (fpu_in_ready_i),
    .fpu_flush_o    (fpu_flush_o),
    .fpu_out_valid_i(fpu_out_valid_i),
    .fpu_out_ready_o(fpu_out_ready_o),
    .fpu_result_i   (fpu_result_i),
    .fpu_status_i   (fpu_status_i),
    .fp_wb_en_o     (fp_wb_en_o),
    .int_wb_en_o    (int_wb_en_o),
    .wb_addr_o      (wb_addr_o),
    .wb_data_o      (wb_data_o),
    .stall_o        (stall_o),
`ifdef FP_FFLAGS_ACCUM_EN
    .fflags_o       (fflags_o),
    .fflags_clr_i   (fflags_clr_i),
`endif
    .timeout_o      (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state at transaction level.
  bit       to_model = 1'b0;
  bit [4:0] ff_model = 5'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_quiet();
    id_valid_i      = 1'b0;
    id_instr_i      = $urandom;
    id_rd_i         = 5'($urandom);
    id_int_wb_i     = 1'($urandom);
    flush_i         = 1'b0;
    fpu_in_ready_i  = 1'($urandom);
    fpu_out_valid_i = 1'($urandom);
    fpu_result_i    = $urandom;
    fpu_status_i    = 5'($urandom);
`ifdef FP_FFLAGS_ACCUM_EN
    fflags_clr_i    = 1'b0;
`endif
  endtask

  // One idle cycle: the controller must be ready, not stalling and not writing back.
  task automatic idle_check(input bit clr);
    @(negedge clk_i);
    drive_quiet();
`ifdef FP_FFLAGS_ACCUM_EN
    fflags_clr_i = clr;
`endif
    #1;
    check("idle_id_ready", id_ready_o, 1'b0 | 1'b1);
    check("idle_stall", stall_o, 1'b0);
    check("idle_wb", {fp_wb_en_o, int_wb_en_o}, 2'b00);
    check("idle_out_ready", fpu_out_ready_o, 1'b0);
    check("timeout_sticky", timeout_o, to_model);
`ifdef FP_FFLAGS_ACCUM_EN
    check("fflags", fflags_o, ff_model);
    if (clr) ff_model = 5'h0;
`else
    if (clr) ff_model = 5'h0;
`endif
  endtask

  // Drives one instruction through its whole life. iw = ready-low cycles in ISSUE,
  // rw = valid-low cycles in WAIT before the result, flush_sel < 0 means no flush,
  // otherwise flush lands on offset (flush_sel mod op length) after acceptance.
  task automatic run_op(input logic [31:0] instr, input logic [4:0] rd, input logic iwb,
                        input int iw, input int rw, input int flush_sel,
                        input logic [31:0] res, input logic [4:0] st, input bit clr_at_wb);
    int issue_end, wait_start, wait_len, wb_off, end_off, flush_off;
    bit delivers, fl, in_issue, in_wait, is_wb, is_to;
    issue_end  = 1 + iw;
    wait_start = 2 + iw;
    delivers   = (rw + 1 <= T);
    wait_len   = delivers ? rw + 1 : T;
    wb_off     = wait_start + wait_len;
    end_off    = delivers ? wb_off : wait_start + T - 1;
    flush_off  = (flush_sel < 0) ? -1 : flush_sel % (end_off + 1);
    for (int off = 0; off <= end_off; off++) begin
      fl       = (off == flush_off);
      in_issue = (off >= 1) && (off <= issue_end);
      in_wait  = (off >= wait_start) && (off < wait_start + wait_len);
      is_wb    = delivers && (off == wb_off);
      is_to    = !delivers && (off == end_off);
      @(negedge clk_i);
      drive_quiet();
      id_valid_i = (off == 0);
      if (off == 0) begin
        id_instr_i  = instr;
        id_rd_i     = rd;
        id_int_wb_i = iwb;
      end
      if (in_issue) fpu_in_ready_i = (off == issue_end);
      if (in_wait) begin
        fpu_out_valid_i = delivers && (off == wait_start + rw);
        if (fpu_out_valid_i) begin
          fpu_result_i = res;
          fpu_status_i = st;
        end
      end
      flush_i = fl;
`ifdef FP_FFLAGS_ACCUM_EN
      fflags_clr_i = is_wb ? clr_at_wb : 1'b0;
`endif
      #1;
      check("id_ready", id_ready_o, (off == 0) && !fl);
      check("stall", stall_o, (off == 0) ? !fl : 1'b1);
      check("fpu_valid", fpu_valid_o, in_issue && !fl);
      if (in_issue) check("fpu_instr", fpu_instr_o, instr);
      check("out_ready", fpu_out_ready_o, in_wait && !fl);
      check("fpu_flush", fpu_flush_o, fl || is_to);
      check("fp_wb_en", fp_wb_en_o, is_wb && !fl && !iwb);
      check("int_wb_en", int_wb_en_o, is_wb && !fl && iwb);
      if (is_wb && !fl) begin
        check("wb_addr", wb_addr_o, rd);
        check("wb_data", wb_data_o, res);
        ff_model = (clr_at_wb ? 5'h0 : ff_model) | st;
      end
      if (is_to && !fl) to_model = 1'b1;
      if (fl) break;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    drive_quiet();
    rst_i = 1'b1;
    #1;
    check("rst_id_ready", id_ready_o, 1'b0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_wb", {fp_wb_en_o, int_wb_en_o, fpu_valid_o, fpu_flush_o}, 4'b0000);
    @(negedge clk_i);
    rst_i = 1'b0;
    to_model = 1'b0;
    ff_model = 5'h0;
    #1;
    check("post_rst_instr", fpu_instr_o, 32'h0);
    check("post_rst_timeout", timeout_o, 1'b0);
    check("post_rst_id_ready", id_ready_o, 1'b1);
    check("post_rst_stall", stall_o, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    drive_quiet();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    apply_reset();

    // Test-plan scenarios.
    run_op(32'h0020_81d3, 5'd5, 1'b0, 0, 2, -1, 32'h4040_0000, 5'h00, 1'b0);
    idle_check(1'b0);
    run_op(32'h1234_5678, 5'd7, 1'b0, 4, 0, -1, 32'hdead_beef, 5'h00, 1'b0);
    idle_check(1'b0);
    run_op(32'ha020_a553, 5'd10, 1'b1, 0, 0, -1, 32'h0000_0001, 5'h00, 1'b0);
    idle_check(1'b0);
    run_op(32'h0000_0053, 5'd3, 1'b0, 0, 1, 3, 32'h3f80_0000, 5'h00, 1'b0);
    idle_check(1'b0);
    run_op(32'h0000_0053, 5'd4, 1'b0, 1, 100, -1, 32'h0, 5'h00, 1'b0);
    idle_check(1'b0);
    check("timeout_set", timeout_o, 1'b1);
    idle_check(1'b0);

    // Reset while an op sits in WAIT: no write-back, timeout cleared.
    @(negedge clk_i);
    drive_quiet();
    id_valid_i = 1'b1;
    @(negedge clk_i);
    drive_quiet();
    fpu_in_ready_i = 1'b1;
    apply_reset();
    idle_check(1'b0);

    // Flag accumulation: 0x01 then 0x10 gives 0x11; a clear returns it to 0.
    run_op(32'h1, 5'd1, 1'b0, 0, 0, -1, 32'h1, 5'h01, 1'b0);
    idle_check(1'b0);
    run_op(32'h2, 5'd2, 1'b0, 0, 0, -1, 32'h2, 5'h10, 1'b0);
    idle_check(1'b1);
`ifdef FP_FFLAGS_ACCUM_EN
    check("fflags_accum", fflags_o, 5'h11);
`endif
    idle_check(1'b0);

    // Randomized transactions with backpressure, spurious results, flushes and timeouts.
    for (int n = 0; n < 80; n++) begin
      int iw, rw, fs;
      iw = int'($urandom_range(0, 5));
      rw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(T - 1, T + 3))
                                       : int'($urandom_range(0, T - 1));
      fs = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 63)) : -1;
      run_op($urandom, 5'($urandom), 1'($urandom), iw, rw, fs, $urandom, 5'($urandom),
             1'($urandom_range(0, 3) == 0));
      idle_check($urandom_range(0, 5) == 0);
    end

    apply_reset();
    idle_check(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
